// File: rtl/force_bus_pkg.sv
// Shared types and constants for the force/release bus controller.
package force_bus_pkg;

    localparam int unsigned OP_W     = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned SETTLE_W = 4;

    typedef enum logic [OP_W-1:0] {
        OpNop        = 2'd0,
        OpForce      = 2'd1,
        OpRelease    = 2'd2,
        OpReleaseAll = 2'd3
    } force_op_e;

    typedef enum logic [1:0] {
        StIdle,
        StApply,
        StSettle,
        StDone
    } force_state_e;

endpackage

// File: rtl/force_overlay_reg.sv
// Force mask/value registers and the registered overlay of forced bits onto
// the functional bus values.
module force_overlay_reg
    import force_bus_pkg::*;
#(
    parameter int unsigned WA = 4,
    parameter int unsigned WB = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WA-1:0]     func_a,
    input  logic [WB-1:0]     func_b,
    input  logic              apply,
    input  force_op_e         op,
    input  logic [WA+WB-1:0]  mask,
    input  logic [WA+WB-1:0]  value,
    output logic [WA-1:0]     busa,
    output logic [WB-1:0]     busb,
    output logic [WA+WB-1:0]  forced_mask
);
    localparam int unsigned W = WA + WB;

    logic [W-1:0] mask_q, mask_d;
    logic [W-1:0] val_q, val_d;

    // Next mask/value from the captured op; released bits also clear the value.
    always_comb begin
        mask_d = mask_q;
        val_d  = val_q;
        if (apply) begin
            unique case (op)
                OpForce: begin
                    mask_d = mask_q | mask;
                    val_d  = (val_q & ~mask) | (value & mask);
                end
                OpRelease: begin
                    mask_d = mask_q & ~mask;
                    val_d  = val_q & ~mask;
                end
                OpReleaseAll: begin
                    mask_d = '0;
                    val_d  = '0;
                end
                default: ;
            endcase
        end
    end

    // Mask and value state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
            val_q  <= '0;
        end else begin
            mask_q <= mask_d;
            val_q  <= val_d;
        end
    end

    // Overlay register, updated every cycle regardless of controller state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {busa, busb} <= '0;
        end else begin
            {busa, busb} <= ({func_a, func_b} & ~mask_q) | (val_q & mask_q);
        end
    end

    assign forced_mask = mask_q;

endmodule

// File: rtl/force_bus_ctl.sv
// Handshaked force/release controller: accepts one command at a time, applies
// it to the overlay registers, waits for it to settle and pulses done.
module force_bus_ctl
    import force_bus_pkg::*;
#(
    parameter int unsigned WA     = 4,
    parameter int unsigned WB     = 4,
    parameter int unsigned SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WA-1:0]     func_a,
    input  logic [WB-1:0]     func_b,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [WA+WB-1:0]  cmd_mask,
    input  logic [WA+WB-1:0]  cmd_value,
    output logic [WA-1:0]     busa,
    output logic [WB-1:0]     busb,
    output logic [WA+WB-1:0]  forced_mask,
    output logic              done,
    output logic [CNT_W-1:0]  force_cnt
);
    localparam int unsigned W = WA + WB;
    localparam logic [SETTLE_W-1:0] SettleLoad = SETTLE_W'(SETTLE - 1);

    if (SETTLE == 0 || SETTLE > 15) begin : g_settle_check
        $error("force_bus_ctl: SETTLE must be in the range 1..15");
    end

    force_state_e         state_q, state_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d;
    force_op_e            op_q;
    logic [W-1:0]         cmask_q, cval_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 accept;
    logic                 apply;

    // Command handshake and settle sequencing.
    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        cmd_ready = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        apply     = 1'b0;
        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = StApply;
                end
            end
            StApply: begin
                apply    = 1'b1;
                settle_d = SettleLoad;
                state_d  = StSettle;
            end
            StSettle: begin
                if (settle_q == '0) begin
                    state_d = StDone;
                end else begin
                    settle_d = settle_q - SETTLE_W'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM state and settle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // Capture the command on acceptance; later cmd_* changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OpNop;
            cmask_q <= '0;
            cval_q  <= '0;
        end else if (accept) begin
            op_q    <= force_op_e'(cmd_op);
            cmask_q <= cmd_mask;
            cval_q  <= cmd_value;
        end
    end

    // Saturating count of FORCE commands that actually select bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (apply && op_q == OpForce && cmask_q != '0 && cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign force_cnt = cnt_q;

    force_overlay_reg #(
        .WA (WA),
        .WB (WB)
    ) u_overlay (
        .clk         (clk),
        .rst_n       (rst_n),
        .func_a      (func_a),
        .func_b      (func_b),
        .apply       (apply),
        .op          (op_q),
        .mask        (cmask_q),
        .value       (cval_q),
        .busa        (busa),
        .busb        (busb),
        .forced_mask (forced_mask)
    );

endmodule
